// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Package     : if_id_pkg
// Description : Shared types and constants for the IF/ID fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

    localparam int IFQ_DEPTH_DEF = 4;
    localparam int IFQ_XLEN_DEF  = 32;

    // addi x0, x0, 0 - presented to decode whenever no packet is available
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One fetched packet as it travels from fetch to decode
    typedef struct packed {
        logic [IFQ_XLEN_DEF-1:0] pc;
        logic [IFQ_XLEN_DEF-1:0] npc;
        logic [IFQ_XLEN_DEF-1:0] ir;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/if_id_fetch_queue_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifq_ptr_ctrl
// Description : Head/tail pointers and occupancy counter of the IF/ID queue.
//               Decides write/read enables, full/empty and flush priority.
//               Optional macro IFQ_BYPASS_EN: an empty queue hands a new
//               packet straight to decode and skips the write when decode
//               accepts it in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_ptr_ctrl
    import if_id_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_enq_req,
    input  logic          i_hazard,
    input  logic          i_flush,
    output logic          o_wr_en,
    output logic          o_rd_en,
    output logic          o_bypass,
    output logic          o_full,
    output logic          o_empty,
    output logic [PW-1:0] o_head,
    output logic [PW-1:0] o_tail,
    output logic [CW-1:0] o_count
);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_wr_en;
    logic w_rd_en;

    // Status comes from the counter alone, so full never depends on dequeue
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
`ifdef IFQ_BYPASS_EN
        w_bypass = w_empty & i_enq_req & ~i_flush;
`else
        w_bypass = 1'b0;
`endif
        // A bypassed packet consumed by decode this cycle is never stored
        w_wr_en = i_enq_req & ~w_full & ~i_flush & ~(w_bypass & ~i_hazard);
        w_rd_en = ~w_empty & ~i_hazard & ~i_flush;
    end

    // Pointer and occupancy update; flush overrides every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_rd_en) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_en  = w_wr_en;
    assign o_rd_en  = w_rd_en;
    assign o_bypass = w_bypass;
    assign o_full   = w_full;
    assign o_empty  = w_empty;
    assign o_head   = r_head;
    assign o_tail   = r_tail;
    assign o_count  = r_count;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rd_en && (r_count == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_wr_en && (r_count == CW'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_queue
// Description : Decoupling FIFO between fetch and decode. Buffers
//               {PC, NPC, IR} packets, flushes on a taken branch and
//               reports full so fetch can hold its PC.
//               Optional macro IFQ_BYPASS_EN: zero-latency path from fetch
//               to decode when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEF,
    // fetch_pkt_t fields are IFQ_XLEN_DEF wide; XLEN must match it
    parameter int XLEN  = IFQ_XLEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_valid_inst_in,
    input  logic [XLEN-1:0]        if_pc_in,
    input  logic [XLEN-1:0]        if_npc_in,
    input  logic [XLEN-1:0]        if_ir_in,
    input  logic                   d_hazard_detected,
    input  logic                   ex_take_branch_out,
    output logic                   ifq_full,
    output logic                   id_valid_inst_out,
    output logic [XLEN-1:0]        id_pc_out,
    output logic [XLEN-1:0]        id_npc_out,
    output logic [XLEN-1:0]        id_ir_out,
    output logic [$clog2(DEPTH):0] ifq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_bypass;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_tail;
    logic [CW-1:0] w_count;

    fetch_pkt_t    w_in_pkt;
    fetch_pkt_t    w_head_pkt;
    fetch_pkt_t    r_mem [DEPTH];

    logic [XLEN-1:0] r_last_pc;
    logic [XLEN-1:0] r_last_npc;

    ifq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enq_req (if_valid_inst_in),
        .i_hazard  (d_hazard_detected),
        .i_flush   (ex_take_branch_out),
        .o_wr_en   (w_wr_en),
        .o_rd_en   (w_rd_en),
        .o_bypass  (w_bypass),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head),
        .o_tail    (w_tail),
        .o_count   (w_count)
    );

    assign w_in_pkt.pc  = if_pc_in;
    assign w_in_pkt.npc = if_npc_in;
    assign w_in_pkt.ir  = if_ir_in;
    assign w_head_pkt   = r_mem[w_head];

    // Packet storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_tail] <= w_in_pkt;
        end
    end

    // Remember the PC/NPC last shown to decode so an empty queue holds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pc  <= '0;
            r_last_npc <= '0;
        end else if (id_valid_inst_out) begin
            r_last_pc  <= id_pc_out;
            r_last_npc <= id_npc_out;
        end
    end

    // Decode-side view: bypassed input, queue head, or NOP with held PC/NPC
    always_comb begin
        id_valid_inst_out = 1'b0;
        id_pc_out         = r_last_pc;
        id_npc_out        = r_last_npc;
        id_ir_out         = NOP_INST;
        if (w_bypass) begin
            id_valid_inst_out = 1'b1;
            id_pc_out         = if_pc_in;
            id_npc_out        = if_npc_in;
            id_ir_out         = if_ir_in;
        end else if (!w_empty) begin
            id_valid_inst_out = 1'b1;
            id_pc_out         = w_head_pkt.pc;
            id_npc_out        = w_head_pkt.npc;
            id_ir_out         = w_head_pkt.ir;
        end
    end

    assign ifq_full  = w_full;
    assign ifq_count = w_count;

endmodule
`default_nettype wire
